// File: rtl/nbit_divider.sv
// Sequential unsigned N-bit divider (restoring shift-subtract, one quotient bit per clock).
// A division is requested with a start/done handshake. The quotient, remainder and
// divide-by-zero flag stay in registers until the next request completes.
// A zero divisor skips the iteration. It finishes one cycle after acceptance with an
// all-ones quotient and the dividend as remainder.

module nbit_divider #(
  parameter int N = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         divByZero
);

  // The step counter only has to reach N-1, so this width always leaves headroom.
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [N:0]    rem_acc;
  logic [N-1:0]  quo_sh;
  logic [N-1:0]  div_reg;
  logic [CW-1:0] count;

  logic [N:0]    rem_shift;
  logic [N:0]    rem_diff;
  logic          rem_ge;
  logic [N:0]    rem_step;
  logic [N-1:0]  quo_step;
  logic          accept;
  logic          last_step;

  // Build one restoring iteration: shift the next dividend bit into the partial
  // remainder, then try subtracting the divisor. The compare result is the new quotient bit.
  always_comb begin
    rem_shift = {rem_acc[N-1:0], quo_sh[N-1]};
    rem_diff  = rem_shift - {1'b0, div_reg};
    rem_ge    = (rem_shift >= {1'b0, div_reg});
    rem_step  = rem_ge ? rem_diff : rem_shift;
    quo_step  = {quo_sh[N-2:0], rem_ge};
  end

  // A new request can be taken whenever no iteration is in flight, including the done cycle.
  always_comb begin
    accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    last_step = (count == CW'(N - 1));
  end

  // Control and datapath registers. Reset has priority and throws away any division in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      rem_acc   <= '0;
      quo_sh    <= '0;
      div_reg   <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            div_reg   <= divisor;
            quo_sh    <= dividend;
            rem_acc   <= '0;
            count     <= '0;
            divByZero <= 1'b0;
            if (divisor == '0) begin
              state     <= ST_DONE;
              quotient  <= '1;
              remainder <= dividend;
              divByZero <= 1'b1;
            end else begin
              state <= ST_CALC;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_acc <= rem_step;
          quo_sh  <= quo_step;
          count   <= count + 1'b1;
          if (last_step) begin
            state     <= ST_DONE;
            quotient  <= quo_step;
            remainder <= rem_step[N-1:0];
            count     <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Both status flags are decoded from the registered state, so they are glitch-free.
  always_comb begin
    busy = (state == ST_CALC);
    done = (state == ST_DONE);
  end

endmodule
